// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the signed 32-bit multiply/divide unit: op encoding,
// FSM states, widths, iteration counts and a magnitude helper.
package mul_div_unit_pkg;

  localparam int DATA_W    = 32;
  localparam int MUL_STEPS = 16;
  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = 6;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    MUL_ITER,
    DIV_ITER,
    FIXUP,
    DONE
  } state_e;

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_booth_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window onto a partial
// product of {0, +-1, +-2} x multiplicand, sign-extended to DATA_W+2 bits.
module booth_recoder
  import mul_div_unit_pkg::*;
(
  input  logic [2:0]               window,
  input  logic signed [DATA_W-1:0] mcand,
  output logic signed [DATA_W+1:0] pp
);

  logic signed [DATA_W+1:0] m_ext;

  always_comb begin
    m_ext = {{2{mcand[DATA_W-1]}}, mcand};
    pp    = '0;
    unique case (window)
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext <<< 1;
      3'b100:         pp = -(m_ext <<< 1);
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply (radix-4 Booth, 16 steps) and divide (restoring,
// 32 steps + sign fixup) sharing one accumulator and one step counter.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic [2*DATA_W-1:0]      result
);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2*DATA_W-1:0]      acc_q, acc_d;
  logic [2*DATA_W-1:0]      result_q, result_d;

  // Booth step: partial product weighted by 4^step, added into the accumulator
  logic [DATA_W:0]            mplier_ext;
  logic [2:0]                 window;
  logic signed [DATA_W+1:0]   pp;
  logic signed [2*DATA_W-1:0] pp_ext;
  logic [2*DATA_W-1:0]        acc_mul_next;

  assign mplier_ext   = {b_q, 1'b0};
  assign window       = mplier_ext[{cnt_q[3:0], 1'b0} +: 3];
  assign pp_ext       = {{(DATA_W-2){pp[DATA_W+1]}}, pp};
  assign acc_mul_next = acc_q + (pp_ext << {cnt_q[3:0], 1'b0});

  booth_recoder u_booth (
    .window (window),
    .mcand  (a_q),
    .pp     (pp)
  );

  // Restoring divide: acc holds {partial remainder, dividend/quotient bits}
  logic [DATA_W-1:0] dvs;
  logic [DATA_W:0]   shifted, diff;
  logic [DATA_W-1:0] q_fix, r_fix;

  assign dvs     = magnitude(b_q);
  assign shifted = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign q_fix   = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign r_fix   = a_q[DATA_W-1] ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          cnt_d = '0;
          if (op == OP_MUL) begin
            acc_d   = '0;
            state_d = MUL_ITER;
          end else if (b == '0) begin
            result_d = {a, {DATA_W{1'b1}}};
            state_d  = DONE;
          end else begin
            acc_d   = {{DATA_W{1'b0}}, magnitude(a)};
            state_d = DIV_ITER;
          end
        end
      end
      MUL_ITER: begin
        acc_d = acc_mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MUL_STEPS - 1)) begin
          result_d = acc_mul_next;
          state_d  = DONE;
        end
      end
      DIV_ITER: begin
        if (!diff[DATA_W]) acc_d = {diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        else               acc_d = {shifted[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_STEPS - 1)) state_d = FIXUP;
      end
      FIXUP: begin
        result_d = {r_fix, q_fix};
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
